ysyx_25060170_lsu: RTL and testbench
====================================

// Module: ysyx_25060170_lsu
// PURPOSE
//  Load/store stage; the consumer end of the EXU->LSU valid/ready handshake.
//  - Accepts exu_res (address or ALU result), store_data and rd_addr from the EXU.
//  - Runs one SRAM-style bus transaction per memory op: byte lanes, mask, load extension.
//  - Hands a registered result to WBU over a second valid/ready pair.
// PARAMETERS
//  ADDR_W  32  bus address width; exu_res width
//  DATA_W  32  data width; only 32 is supported
//  REG_W   5   rd_addr width
// PORTS
//  clk         in   1       clock; all state on rising edge
//  rst         in   1       asynchronous, active-low reset
//  ex_valid    in   1       EXU has an op for LSU
//  ls_ready    out  1       LSU can accept an op this cycle
//  exu_res     in   ADDR_W  memory address, or pass-through result
//  store_data  in   DATA_W  rs2 value for stores
//  rd_addr     in   REG_W   destination register
//  ls_ren      in   1       load op
//  ls_wen      in   1       store op; ls_ren&ls_wen is illegal
//  ls_size     in   2       00 byte, 01 half, 10 word
//  ls_unsigned in   1       zero-extend the load (LBU/LHU)
//  mem_req     out  1       bus request
//  mem_we      out  1       1 = write
//  mem_addr    out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
//  mem_wdata   out  DATA_W  lane-replicated store data
//  mem_wmask   out  4       byte write strobes
//  mem_gnt     in   1       request accepted
//  mem_rvalid  in   1       response / write completion
//  mem_rdata   in   DATA_W  read word
//  ls_valid    out  1       result valid to WBU
//  wb_ready    in   1       WBU accepts the result
//  wb_data     out  DATA_W  load data or pass-through exu_res
//  wb_rd_addr  out  REG_W   destination register
//  ls_misalign out  1       misaligned-access flag; only with the macro
// BEHAVIOUR
//  - Reset (rst=0, async): state=IDLE; all outputs and registers = 0, except ls_ready=1 once state is IDLE.
//  - ls_ready = (state==IDLE) & (~ls_valid | wb_ready). An op is accepted when ex_valid & ls_ready.
//  - FSM states:
//    - IDLE: a non-memory op goes straight to the output register in 1 cycle (wb_data=exu_res).
//      A memory op latches addr, data, size, sign and rd, then goes to REQ.
//    - REQ: mem_req=1, all mem_* fields held stable until mem_gnt.
//      gnt & rvalid in the same cycle -> DONE; gnt alone -> WAIT.
//    - WAIT: mem_req=0; wait for mem_rvalid -> DONE.
//    - DONE: load result into the output register; ls_valid=1; -> IDLE.
//  - Output register holds wb_data, wb_rd_addr and ls_valid until wb_ready. ls_valid then clears unless a new result loads in the same cycle.
//  - Minimum latency: pass-through 1 cycle; memory op 3 cycles (accept, REQ with gnt+rvalid, DONE).
//  - Store lanes:
//    - byte: wmask=4'b0001<<a[1:0]; wdata={4{sd[7:0]}}
//    - half: wmask=4'b0011<<{a[1],1'b0}; wdata={2{sd[15:0]}}
//    - word: wmask=4'hF; wdata=sd
//    - loads: wmask=0, mem_we=0.
//  - Load: rdata shifted right by a[1:0]*8, truncated to size, then sign- or zero-extended per ls_unsigned.
//  - mem_rvalid in IDLE or REQ-without-gnt is ignored. ls_size=11 is treated as word.
//  - Reset mid-transaction abandons it; a late mem_rvalid after reset is ignored.
// CONFIGURATION
//  - YSYX_25060170_LSU_MISALIGN_CHK_EN defined:
//    - Half with a[0]=1, or word with a[1:0]!=0, skips the bus (IDLE->DONE).
//    - wb_data=0; ls_misalign=1 alongside ls_valid, held with it.
//  - Undefined: no check; ls_misalign tied 0; the address is used as-is (lanes per rules above).
// TESTING
//  - Reset mid-WAIT: assert rst=0 -> all outputs 0 immediately; after release a stale mem_rvalid=1 changes nothing.
//  - LW, a=0x80000004, gnt+rvalid same cycle, rdata=0xDEADBEEF -> mem_addr=0x80000004, wmask=0, wb_data=0xDEADBEEF, ls_valid 3 cycles after accept.
//  - LB, a=0x80000003, rdata=0x80FF7F01 -> wb_data=0xFFFFFF80; LBU same access -> 0x00000080.
//  - SH, a=0x80000002, sd=0x1234ABCD -> mem_we=1, wmask=4'b1100, wdata=0xABCDABCD; gnt delayed 3 cycles -> fields stable throughout.
//  - Pass-through exu_res=0x42, rd=5, wb_ready=0 for 4 cycles -> ls_valid held, ls_ready=0, wb_data=0x42 stable; next op accepted in the wb_ready cycle.
//  - With macro, LW a=0x80000002 -> no mem_req, ls_misalign=1, wb_data=0.

Source files
------------

// File: rtl/ysyx_25060170_lsu_if.sv
// Handshake/bus bundles around the load/store unit: EXU->LSU op, SRAM-style
// memory bus, and LSU->WBU result. Each bundle has master/slave views.

interface ysyx_25060170_exu_ls_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              ex_valid;
  logic              ls_ready;
  logic [ADDR_W-1:0] exu_res;
  logic [DATA_W-1:0] store_data;
  logic [REG_W-1:0]  rd_addr;
  logic              ls_ren;
  logic              ls_wen;
  logic [1:0]        ls_size;
  logic              ls_unsigned;

  modport master (
    output ex_valid, exu_res, store_data, rd_addr, ls_ren, ls_wen, ls_size, ls_unsigned,
    input  ls_ready
  );
  modport slave (
    input  ex_valid, exu_res, store_data, rd_addr, ls_ren, ls_wen, ls_size, ls_unsigned,
    output ls_ready
  );
endinterface

interface ysyx_25060170_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wmask;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

interface ysyx_25060170_ls_wb_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
);
  logic              ls_valid;
  logic              wb_ready;
  logic [DATA_W-1:0] wb_data;
  logic [REG_W-1:0]  wb_rd_addr;
  logic              ls_misalign;

  modport master (
    output ls_valid, wb_data, wb_rd_addr, ls_misalign,
    input  wb_ready
  );
  modport slave (
    input  ls_valid, wb_data, wb_rd_addr, ls_misalign,
    output wb_ready
  );
endinterface

// File: rtl/ysyx_25060170_lsu.sv
// Load/store stage: one SRAM-style bus transaction per memory op, registered result to WBU.
// Optional misaligned-access trap: define YSYX_25060170_LSU_MISALIGN_CHK_EN.

module ysyx_25060170_lsu #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_25060170_exu_ls_if.slave         exu_if,
  ysyx_25060170_mem_if.master           mem_if,
  ysyx_25060170_ls_wb_if.master         wb_if
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [3:0]        wmask_q;
  logic              we_q, uns_q, mis_q;
  logic [1:0]        size_q;
  logic [REG_W-1:0]  rd_q;

  logic              out_valid_q, out_mis_q;
  logic [DATA_W-1:0] out_data_q;
  logic [REG_W-1:0]  out_rd_q;

  logic              ls_ready, accept, mem_op, misalign;
  logic              latch_op, cap_rdata, load_out;
  logic [3:0]        wmask_n;
  logic [DATA_W-1:0] wdata_n, shifted, load_ext, out_data_n;
  logic [REG_W-1:0]  out_rd_n;
  logic              out_mis_n;

  assign ls_ready = (state_q == S_IDLE) & (~out_valid_q | wb_if.wb_ready);
  assign accept   = exu_if.ex_valid & ls_ready;
  assign mem_op   = exu_if.ls_ren | exu_if.ls_wen;

`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
  // Size 2'b11 decodes as word, so any size with bit 1 set needs word alignment.
  assign misalign = ((exu_if.ls_size == 2'b01) & exu_if.exu_res[0]) |
                    (exu_if.ls_size[1] & (exu_if.exu_res[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Store lanes are resolved at accept time so the bus fields come straight from flops.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    wmask_n = 4'hF;
    wdata_n = exu_if.store_data;
    case (exu_if.ls_size)
      2'b00: begin
        wmask_n = 4'b0001 << exu_if.exu_res[1:0];
        wdata_n = {4{exu_if.store_data[7:0]}};
      end
      2'b01: begin
        wmask_n = 4'b0011 << {exu_if.exu_res[1], 1'b0};
        wdata_n = {2{exu_if.store_data[15:0]}};
      end
      default: ;
    endcase
    if (!exu_if.ls_wen) wmask_n = 4'h0;
  end

  assign shifted = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    case (size_q)
      2'b00: load_ext = uns_q ? {{(DATA_W-8){1'b0}}, shifted[7:0]}
                              : {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
      2'b01: load_ext = uns_q ? {{(DATA_W-16){1'b0}}, shifted[15:0]}
                              : {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    latch_op   = 1'b0;
    cap_rdata  = 1'b0;
    load_out   = 1'b0;
    out_data_n = DATA_W'(exu_if.exu_res);
    out_rd_n   = exu_if.rd_addr;
    out_mis_n  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (mem_op) begin
            latch_op = 1'b1;
            state_d  = misalign ? S_DONE : S_REQ;
          end else begin
            load_out = 1'b1;
          end
        end
      end
      S_REQ: begin
        if (mem_if.mem_gnt) begin
          cap_rdata = mem_if.mem_rvalid;
          state_d   = mem_if.mem_rvalid ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_if.mem_rvalid) begin
          cap_rdata = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        load_out   = 1'b1;
        out_rd_n   = rd_q;
        out_mis_n  = mis_q;
        out_data_n = (mis_q | we_q) ? '0 : load_ext;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      mis_q   <= 1'b0;
      size_q  <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
    end else begin
      if (latch_op) begin
        addr_q  <= exu_if.exu_res;
        wdata_q <= wdata_n;
        wmask_q <= wmask_n;
        we_q    <= exu_if.ls_wen;
        uns_q   <= exu_if.ls_unsigned;
        mis_q   <= misalign;
        size_q  <= exu_if.ls_size;
        rd_q    <= exu_if.rd_addr;
      end
      if (cap_rdata) rdata_q <= mem_if.mem_rdata;
    end
  end

  // Result register: held until WBU takes it; a same-cycle reload wins over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_mis_q   <= 1'b0;
      out_data_q  <= '0;
      out_rd_q    <= '0;
    end else if (load_out) begin
      out_valid_q <= 1'b1;
      out_mis_q   <= out_mis_n;
      out_data_q  <= out_data_n;
      out_rd_q    <= out_rd_n;
    end else if (wb_if.wb_ready) begin
      out_valid_q <= 1'b0;
      out_mis_q   <= 1'b0;
    end
  end

  assign exu_if.ls_ready  = ls_ready;

  assign mem_if.mem_req   = (state_q == S_REQ);
  assign mem_if.mem_we    = we_q & (state_q == S_REQ);
  assign mem_if.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_if.mem_wdata = wdata_q;
  assign mem_if.mem_wmask = (state_q == S_REQ) ? wmask_q : 4'h0;

  assign wb_if.ls_valid    = out_valid_q;
  assign wb_if.wb_data     = out_data_q;
  assign wb_if.wb_rd_addr  = out_rd_q;
  assign wb_if.ls_misalign = out_mis_q;

endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// Bench for ysyx_25060170_lsu: directed scenarios plus randomized ops against a
// byte-level reference model; the bench plays the memory slave and the WBU.

module tb_ysyx_25060170_lsu;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_25060170_exu_ls_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W)) exu_if ();
  ysyx_25060170_mem_if    #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))                mem_if ();
  ysyx_25060170_ls_wb_if  #(.DATA_W(DATA_W), .REG_W(REG_W))                  wb_if ();

  ysyx_25060170_lsu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_W(REG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .exu_if (exu_if),
    .mem_if (mem_if),
    .wb_if  (wb_if)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          saw_req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    bit          stable;
    int          lat;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        mis;
    bit          hold_ok;
    bit          timeout;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [31:0] a,
                                           input logic [1:0] size, input logic uns);
    longint unsigned v, base, span;
    int n;
    n    = nbytes(size);
    base = 64'd1 << (8 * (a % 4));
    span = 64'd1 << (8 * n);
    v    = (64'(rdata) / base) % span;
    if (!uns && n < 4 && v >= span / 2) v = v + (64'd1 << 32) - span;
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] sd, input logic [31:0] a, input logic [1:0] size,
                           output logic [3:0] mask, output logic [31:0] wdata);
    int n, start;
    n     = nbytes(size);
    start = (n == 4) ? 0 : (a % 4) - ((a % 4) % n);
    for (int j = 0; j < 4; j++) begin
      wdata[8*j +: 8] = sd[8*(j % n) +: 8];
      mask[j]         = (j >= start) && (j < start + n);
    end
  endtask

  function automatic bit ref_misaligned(input logic [31:0] a, input logic [1:0] size);
`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    return (nbytes(size) == 2 && (a % 2) != 0) || (nbytes(size) == 4 && (a % 4) != 0);
`else
    return (a === 32'hx) && (size === 2'bx);
`endif
  endfunction

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts at posedge+1 with wb_ready=1; ends the same way with the result drained next edge.
  task automatic run_op(input logic ren, input logic wen, input logic [1:0] size, input logic uns,
                        input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                        input int hold, input bit noise, output obs_t o);
    int req_n, gnt_at, w;
    o = '{default: '0};
    o.stable = 1'b1; o.hold_ok = 1'b1; o.lat = -1;
    req_n = 0; gnt_at = -1; w = 0;
    exu_if.ex_valid = 1'b1; exu_if.exu_res = a; exu_if.store_data = sd; exu_if.rd_addr = rd;
    exu_if.ls_ren = ren; exu_if.ls_wen = wen; exu_if.ls_size = size; exu_if.ls_unsigned = uns;
    @(negedge clk);
    while (!exu_if.ls_ready && w < 20) begin
      tick(); @(negedge clk); w++;
    end
    if (!exu_if.ls_ready) begin
      o.timeout = 1'b1; exu_if.ex_valid = 1'b0; tick(); return;
    end
    tick();
    exu_if.ex_valid = 1'b0; wb_if.wb_ready = 1'b0;
    exu_if.exu_res = $urandom; exu_if.store_data = $urandom; exu_if.rd_addr = 5'($urandom);
    exu_if.ls_size = 2'($urandom); exu_if.ls_unsigned = 1'($urandom);
    for (int k = 1; k <= 60; k++) begin
      mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = $urandom;
      if (mem_if.mem_req) begin
        if (!o.saw_req) begin
          o.saw_req = 1'b1; o.we = mem_if.mem_we; o.addr = mem_if.mem_addr;
          o.wdata = mem_if.mem_wdata; o.wmask = mem_if.mem_wmask;
        end else if ({mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask}
                     !== {o.we, o.addr, o.wdata, o.wmask}) begin
          o.stable = 1'b0;
        end
        if (req_n == gnt_dly) begin
          mem_if.mem_gnt = 1'b1; gnt_at = k;
          if (rv_dly == 0) begin mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rdata; end
        end else if (noise) begin
          mem_if.mem_rvalid = 1'($urandom);
        end
        req_n++;
      end else if (gnt_at > 0 && rv_dly > 0 && k == gnt_at + rv_dly) begin
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rdata;
      end
      @(negedge clk);
      if (wb_if.ls_valid) begin
        o.lat = k; o.wb_data = wb_if.wb_data; o.rd = wb_if.wb_rd_addr; o.mis = wb_if.ls_misalign;
        break;
      end
      tick();
    end
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
    if (o.lat < 0) begin
      o.timeout = 1'b1; wb_if.wb_ready = 1'b1; return;
    end
    repeat (hold) begin
      tick(); @(negedge clk);
      if (!wb_if.ls_valid || wb_if.wb_data !== o.wb_data || wb_if.wb_rd_addr !== o.rd ||
          wb_if.ls_misalign !== o.mis) o.hold_ok = 1'b0;
    end
    tick();
    wb_if.wb_ready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask} !== '0)
      begin errors++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h wmask=%h expected all 0",
        mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask); end
    checks++;
    if ({wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr, wb_if.ls_misalign} !== '0)
      begin errors++; $display("FAIL reset_wb: got valid=%b data=%h rd=%0d mis=%b expected all 0",
        wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr, wb_if.ls_misalign); end
    @(negedge clk); rst = 1'b1;
    tick(); @(negedge clk);
    checks++;
    if (exu_if.ls_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready: got %b expected 1", exu_if.ls_ready); end
    tick();
  endtask

  task automatic test_lw();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0004, 32'h5555_AAAA, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, o);
    checks++;
    if (o.timeout || o.lat != 3) begin errors++;
      $display("FAIL lw_latency: got %0d (timeout=%b) expected 3", o.lat, o.timeout); end
    checks++;
    if ({o.saw_req, o.addr, o.we, o.wmask} !== {1'b1, 32'h8000_0004, 1'b0, 4'h0}) begin errors++;
      $display("FAIL lw_bus: got req=%b addr=%h we=%b wmask=%h expected req=1 addr=80000004 we=0 wmask=0",
        o.saw_req, o.addr, o.we, o.wmask); end
    checks++;
    if (o.wb_data !== 32'hDEAD_BEEF || o.rd !== 5'd3) begin errors++;
      $display("FAIL lw_data: got %h rd=%0d expected deadbeef rd=3", o.wb_data, o.rd); end
  endtask

  task automatic test_lb_lbu();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h8000_0003, 32'h0, 5'd7, 32'h80FF_7F01, 1, 0, 1, 1'b1, o);
    checks++;
    if (o.timeout || o.wb_data !== 32'hFFFF_FF80 || !o.hold_ok) begin errors++;
      $display("FAIL lb_sext: got %h hold=%b expected ffffff80", o.wb_data, o.hold_ok); end
    run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h8000_0003, 32'h0, 5'd8, 32'h80FF_7F01, 0, 1, 0, 1'b0, o);
    checks++;
    if (o.timeout || o.wb_data !== 32'h0000_0080 || o.lat != 4) begin errors++;
      $display("FAIL lbu_zext: got %h lat=%0d expected 00000080 lat=4", o.wb_data, o.lat); end
  endtask

  task automatic test_sh_delayed_gnt();
    obs_t o;
    run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h8000_0002, 32'h1234_ABCD, 5'd0, 32'h0, 3, 2, 0, 1'b1, o);
    checks++;
    if ({o.saw_req, o.we, o.wmask, o.wdata, o.addr} !== {1'b1, 1'b1, 4'b1100, 32'hABCD_ABCD, 32'h8000_0000})
      begin errors++; $display("FAIL sh_bus: got we=%b wmask=%b wdata=%h addr=%h expected we=1 wmask=1100 wdata=abcdabcd addr=80000000",
        o.we, o.wmask, o.wdata, o.addr); end
    checks++;
    if (!o.stable) begin errors++; $display("FAIL sh_stable: got unstable fields expected stable"); end
    checks++;
    if (o.timeout || o.lat != 8) begin errors++;
      $display("FAIL sh_latency: got %0d expected 8", o.lat); end
  endtask

  task automatic test_passthrough_backpressure();
    tick();
    wb_if.wb_ready = 1'b0;
    exu_if.ex_valid = 1'b1; exu_if.exu_res = 32'h42; exu_if.rd_addr = 5'd5;
    exu_if.ls_ren = 1'b0; exu_if.ls_wen = 1'b0; exu_if.ls_size = 2'b10; exu_if.ls_unsigned = 1'b0;
    @(negedge clk);
    checks++;
    if (exu_if.ls_ready !== 1'b1) begin errors++;
      $display("FAIL pt_ready_first: got %b expected 1", exu_if.ls_ready); end
    tick();
    exu_if.exu_res = 32'h77; exu_if.rd_addr = 5'd6;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({wb_if.ls_valid, exu_if.ls_ready, wb_if.wb_data, wb_if.wb_rd_addr} !== {1'b1, 1'b0, 32'h42, 5'd5})
        begin errors++; $display("FAIL pt_hold[%0d]: got valid=%b ready=%b data=%h rd=%0d expected 1 0 42 5",
          i, wb_if.ls_valid, exu_if.ls_ready, wb_if.wb_data, wb_if.wb_rd_addr); end
      tick();
    end
    wb_if.wb_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (exu_if.ls_ready !== 1'b1) begin errors++;
      $display("FAIL pt_ready_release: got %b expected 1", exu_if.ls_ready); end
    tick();
    exu_if.ex_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr} !== {1'b1, 32'h77, 5'd6}) begin errors++;
      $display("FAIL pt_next: got valid=%b data=%h rd=%0d expected 1 77 6",
        wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr); end
    tick();
  endtask

  task automatic test_misalign();
    obs_t o;
    run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h8000_0002, 32'h0, 5'd4, 32'h1122_3344, 0, 0, 0, 1'b0, o);
`ifdef YSYX_25060170_LSU_MISALIGN_CHK_EN
    checks++;
    if ({o.saw_req, o.mis, o.wb_data} !== {1'b0, 1'b1, 32'h0} || o.lat != 2) begin errors++;
      $display("FAIL misalign_trap: got req=%b mis=%b data=%h lat=%0d expected 0 1 0 2",
        o.saw_req, o.mis, o.wb_data, o.lat); end
`else
    checks++;
    if ({o.saw_req, o.mis, o.wb_data} !== {1'b1, 1'b0, 32'h0000_1122} || o.lat != 3) begin errors++;
      $display("FAIL misalign_passthru: got req=%b mis=%b data=%h lat=%0d expected 1 0 00001122 3",
        o.saw_req, o.mis, o.wb_data, o.lat); end
`endif
  endtask

  task automatic test_random();
    obs_t o;
    logic ren, wen, uns, mem, mis;
    logic [1:0] size;
    logic [31:0] a, sd, rdata, exp_data, exp_wdata;
    logic [3:0] exp_mask;
    logic [4:0] rd;
    int sel, gd, rv, hd, exp_lat;
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      ren = (sel >= 3 && sel <= 6); wen = (sel >= 7); mem = ren | wen;
      size = 2'($urandom_range(0, 3)); uns = 1'($urandom);
      a = 32'h8000_0000 | 32'($urandom_range(0, 255));
      sd = $urandom; rdata = $urandom; rd = 5'($urandom);
      gd = $urandom_range(0, 3); rv = $urandom_range(0, 3); hd = $urandom_range(0, 2);
      mis = mem && ref_misaligned(a, size);
      ref_store(sd, a, size, exp_mask, exp_wdata);
      exp_lat  = !mem ? 1 : mis ? 2 : 3 + gd + rv;
      exp_data = !mem ? a : mis ? 32'h0 : ref_load(rdata, a, size, uns);
      run_op(ren, wen, size, uns, a, sd, rd, rdata, gd, rv, hd, 1'($urandom), o);
      checks++;
      if (o.timeout || o.lat != exp_lat) begin errors++;
        $display("FAIL rnd[%0d]_latency: got %0d expected %0d", i, o.lat, exp_lat); end
      checks++;
      if (!o.hold_ok || o.rd !== rd) begin errors++;
        $display("FAIL rnd[%0d]_rd_hold: got rd=%0d hold=%b expected rd=%0d hold=1", i, o.rd, o.hold_ok, rd); end
      checks++;
      if (o.saw_req != (mem && !mis) || o.mis !== mis) begin errors++;
        $display("FAIL rnd[%0d]_path: got req=%b mis=%b expected req=%b mis=%b",
          i, o.saw_req, o.mis, mem && !mis, mis); end
      if (!wen || mis) begin
        checks++;
        if (o.wb_data !== exp_data) begin errors++;
          $display("FAIL rnd[%0d]_data: got %h expected %h", i, o.wb_data, exp_data); end
      end
      if (mem && !mis) begin
        checks++;
        if ({o.addr, o.we, o.wmask} !== {a & ~32'h3, wen, (wen ? exp_mask : 4'h0)} || !o.stable) begin
          errors++; $display("FAIL rnd[%0d]_bus: got addr=%h we=%b wmask=%b stable=%b expected addr=%h we=%b wmask=%b",
            i, o.addr, o.we, o.wmask, o.stable, a & ~32'h3, wen, (wen ? exp_mask : 4'h0)); end
        if (wen) begin
          checks++;
          if (o.wdata !== exp_wdata) begin errors++;
            $display("FAIL rnd[%0d]_wdata: got %h expected %h", i, o.wdata, exp_wdata); end
        end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    exu_if.ex_valid = 1'b1; exu_if.exu_res = 32'h8000_0010; exu_if.rd_addr = 5'd9;
    exu_if.ls_ren = 1'b1; exu_if.ls_wen = 1'b0; exu_if.ls_size = 2'b10; exu_if.ls_unsigned = 1'b0;
    tick();
    exu_if.ex_valid = 1'b0;
    mem_if.mem_gnt = 1'b1;
    tick();
    mem_if.mem_gnt = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_if.mem_req, mem_if.mem_addr} !== {1'b0, 32'h8000_0010}) begin errors++;
      $display("FAIL rst_wait_state: got req=%b addr=%h expected 0 80000010", mem_if.mem_req, mem_if.mem_addr); end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_if.mem_req, mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wmask,
         wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr, wb_if.ls_misalign} !== '0) begin errors++;
      $display("FAIL rst_async: got req=%b addr=%h valid=%b data=%h rd=%0d expected all 0",
        mem_if.mem_req, mem_if.mem_addr, wb_if.ls_valid, wb_if.wb_data, wb_if.wb_rd_addr); end
    @(negedge clk); rst = 1'b1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      tick(); @(negedge clk);
      checks++;
      if ({wb_if.ls_valid, mem_if.mem_req, wb_if.wb_data, exu_if.ls_ready} !== {1'b0, 1'b0, 32'h0, 1'b1})
        begin errors++; $display("FAIL rst_stale_rvalid[%0d]: got valid=%b req=%b data=%h ready=%b expected 0 0 0 1",
          i, wb_if.ls_valid, mem_if.mem_req, wb_if.wb_data, exu_if.ls_ready); end
    end
    mem_if.mem_rvalid = 1'b0;
    tick();
    run_op(1'b1, 1'b0, 2'b01, 1'b0, 32'h8000_0006, 32'h0, 5'd2, 32'h8001_0000, 0, 0, 0, 1'b0, o);
    checks++;
    if (o.timeout || o.wb_data !== 32'hFFFF_8001 || o.lat != 3) begin errors++;
      $display("FAIL rst_recover_lh: got %h lat=%0d expected ffff8001 lat=3", o.wb_data, o.lat); end
  endtask

  initial begin
    rst = 1'b0;
    exu_if.ex_valid = 1'b0; exu_if.exu_res = '0; exu_if.store_data = '0; exu_if.rd_addr = '0;
    exu_if.ls_ren = 1'b0; exu_if.ls_wen = 1'b0; exu_if.ls_size = '0; exu_if.ls_unsigned = 1'b0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
    wb_if.wb_ready = 1'b1;
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh_delayed_gnt();
    test_passthrough_backpressure();
    test_misalign();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
